fibonacci_checker: RTL

Consumer end of the Fibonacci generator stream. It accepts one or two numbers per cycle from a single-rate or double-rate generator and checks them against the sequence 1, 1, 2, 3, 5, … in 16-bit wrap-around arithmetic. It counts matching numbers and latches the first mismatch with diagnostic data. It sits downstream of the generators as an in-design monitor and as the self-check element for generator testbenches.

---
 rtl/fibonacci_checker.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fibonacci_checker.sv
// Fibonacci stream checker: compares one or two numbers per transfer against
// the sequence 1, 1, 2, 3, 5, ... in W-bit wrap-around arithmetic, counts
// matches (saturating) and latches diagnostics for the first mismatch.
module fibonacci_checker #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         in_valid,
  input  logic         in_double,
  input  logic [W-1:0] in_num,
  input  logic [W-1:0] in_num2,
  output logic         in_ready,
  output logic [15:0]  count,
  output logic         err,
  output logic [W-1:0] err_exp,
  output logic [W-1:0] err_got,
  output logic [15:0]  err_index
);

  localparam logic [0:0] ST_CHECK = 1'b0;
  localparam logic [0:0] ST_ERROR = 1'b1;

  logic [0:0]   state_q,     state_d;
  logic [W-1:0] exp0_q,      exp0_d;
  logic [W-1:0] exp1_q,      exp1_d;
  logic [15:0]  count_q,     count_d;
  logic         err_q,       err_d;
  logic [W-1:0] err_exp_q,   err_exp_d;
  logic [W-1:0] err_got_q,   err_got_d;
  logic [15:0]  err_index_q, err_index_d;

  logic lane0_ok;
  logic lane1_ok;

  // Saturating 16-bit add of a small increment; shared by count and err_index.
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign lane0_ok = (in_num  == exp0_q);
  assign lane1_ok = (in_num2 == exp1_q);

  // Next-state: clear restarts everything, otherwise an accepted transfer
  // either advances the sequence or latches the lowest mismatching lane.
  always_comb begin
    state_d     = state_q;
    exp0_d      = exp0_q;
    exp1_d      = exp1_q;
    count_d     = count_q;
    err_d       = err_q;
    err_exp_d   = err_exp_q;
    err_got_d   = err_got_q;
    err_index_d = err_index_q;
    if (clear) begin
      state_d     = ST_CHECK;
      exp0_d      = W'(1);
      exp1_d      = W'(1);
      count_d     = 16'd0;
      err_d       = 1'b0;
      err_exp_d   = '0;
      err_got_d   = '0;
      err_index_d = 16'd0;
    end else if (in_valid && (state_q == ST_CHECK)) begin
      if (!lane0_ok) begin
        state_d     = ST_ERROR;
        err_d       = 1'b1;
        err_exp_d   = exp0_q;
        err_got_d   = in_num;
        err_index_d = count_q;
      end else if (!in_double) begin
        exp0_d  = exp1_q;
        exp1_d  = exp0_q + exp1_q;
        count_d = sat_add(count_q, 2'd1);
      end else if (!lane1_ok) begin
        // Lane 0 was good, so it still counts; the sequence stays frozen.
        state_d     = ST_ERROR;
        err_d       = 1'b1;
        err_exp_d   = exp1_q;
        err_got_d   = in_num2;
        err_index_d = sat_add(count_q, 2'd1);
        count_d     = sat_add(count_q, 2'd1);
      end else begin
        exp0_d  = exp0_q + exp1_q;
        exp1_d  = exp0_q + exp1_q + exp1_q;
        count_d = sat_add(count_q, 2'd2);
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CHECK;
      exp0_q      <= W'(1);
      exp1_q      <= W'(1);
      count_q     <= 16'd0;
      err_q       <= 1'b0;
      err_exp_q   <= '0;
      err_got_q   <= '0;
      err_index_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      exp0_q      <= exp0_d;
      exp1_q      <= exp1_d;
      count_q     <= count_d;
      err_q       <= err_d;
      err_exp_q   <= err_exp_d;
      err_got_q   <= err_got_d;
      err_index_q <= err_index_d;
    end
  end

  assign in_ready  = (state_q == ST_CHECK);
  assign count     = count_q;
  assign err       = err_q;
  assign err_exp   = err_exp_q;
  assign err_got   = err_got_q;
  assign err_index = err_index_q;

endmodule
